// File: rtl/sram_mem_ctrl_pkg.sv
// Shared definitions for the SRAM controller and the CPU control path: bus widths,
// default SRAM timing and the controller state encoding.
package sram_mem_ctrl_pkg;

  localparam int CPU_W        = 16;
  localparam int ADDR_W_DEF   = 18;
  localparam int RD_WAIT_DEF  = 1;
  localparam int WR_SETUP_DEF = 1;
  localparam int WR_PULSE_DEF = 1;
  localparam int WR_HOLD_DEF  = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SU,
    ST_WR_PL,
    ST_WR_HD,
    ST_DONE
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  // Phase counter load value: a phase of n cycles ends when the counter reads zero.
  function automatic logic [3:0] phase_cnt(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_mem_ctrl_if.sv
// CPU request ports (fetch + data) and external async SRAM pins of the memory controller.
interface sram_mem_ctrl_if
  import sram_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic             if_req;
  logic [CPU_W-1:0] if_addr;
  logic             if_ready;
  logic [CPU_W-1:0] if_rdata;

  logic             d_req;
  logic             d_we;
  logic [CPU_W-1:0] d_addr;
  logic [CPU_W-1:0] d_wdata;
  logic             d_ready;
  logic [CPU_W-1:0] d_rdata;

  logic [ADDR_W-1:0] sram_addr;
  logic [15:0]       sram_dq_in;
  logic [15:0]       sram_dq_out;
  logic              sram_dq_oe;
  logic              sram_ce_n;
  logic              sram_oe_n;
  logic              sram_we_n;
  logic              sram_ub_n;
  logic              sram_lb_n;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_dq_in,
    output if_ready, if_rdata, d_ready, d_rdata,
    output sram_addr, sram_dq_out, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, sram_dq_in,
    input  if_ready, if_rdata, d_ready, d_rdata,
    input  sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

endinterface

// File: rtl/sram_mem_ctrl.sv
// Async SRAM controller: arbitrates fetch vs data requests and sequences CE/OE/WE
// with programmable read wait and write setup/pulse/hold phases.
module sram_mem_ctrl
  import sram_mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int RD_WAIT  = RD_WAIT_DEF,
  parameter int WR_SETUP = WR_SETUP_DEF,
  parameter int WR_PULSE = WR_PULSE_DEF,
  parameter int WR_HOLD  = WR_HOLD_DEF
) (
  input  logic           clk,
  input  logic           reset,
  sram_mem_ctrl_if.slave bus
);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg, cnt_next;
  port_t             port_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       wdata_reg;
  logic [15:0]       if_rdata_reg;
  logic [15:0]       d_rdata_reg;

  logic accept;
  logic rd_last;

  assign accept  = (state_reg == ST_IDLE) && (bus.d_req || bus.if_req);
  assign rd_last = (state_reg == ST_RD) && (cnt_reg == 4'd0);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        // Data port wins a tie; a losing fetch simply stays pending for the next IDLE.
        if (bus.d_req && bus.d_we) begin
          if (WR_SETUP > 0) begin
            state_next = ST_WR_SU;
            cnt_next   = phase_cnt(WR_SETUP);
          end else begin
            state_next = ST_WR_PL;
            cnt_next   = phase_cnt(WR_PULSE);
          end
        end else if (bus.d_req || bus.if_req) begin
          state_next = ST_RD;
          cnt_next   = phase_cnt(RD_WAIT + 1);
        end
      end
      ST_RD: begin
        if (cnt_reg == 4'd0) state_next = ST_DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_WR_SU: begin
        if (cnt_reg == 4'd0) begin
          state_next = ST_WR_PL;
          cnt_next   = phase_cnt(WR_PULSE);
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_WR_PL: begin
        if (cnt_reg == 4'd0) begin
          if (WR_HOLD > 0) begin
            state_next = ST_WR_HD;
            cnt_next   = phase_cnt(WR_HOLD);
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      ST_WR_HD: begin
        if (cnt_reg == 4'd0) state_next = ST_DONE;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      port_reg     <= PORT_IF;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Address and store data are captured once so they stay stable for the whole access.
      if (accept) begin
        port_reg <= bus.d_req ? PORT_D : PORT_IF;
        addr_reg <= {{(ADDR_W-CPU_W){1'b0}}, (bus.d_req ? bus.d_addr : bus.if_addr)};
        if (bus.d_req && bus.d_we) wdata_reg <= bus.d_wdata;
      end
      if (rd_last) begin
        if (port_reg == PORT_D) d_rdata_reg  <= bus.sram_dq_in;
        else                    if_rdata_reg <= bus.sram_dq_in;
      end
    end
  end

  // Strobes are decoded from state only, so a reset releases the bus immediately.
  always_comb begin
    bus.sram_ce_n  = 1'b1;
    bus.sram_oe_n  = 1'b1;
    bus.sram_we_n  = 1'b1;
    bus.sram_dq_oe = 1'b0;
    bus.if_ready   = 1'b0;
    bus.d_ready    = 1'b0;
    case (state_reg)
      ST_RD: begin
        bus.sram_ce_n = 1'b0;
        bus.sram_oe_n = 1'b0;
      end
      ST_WR_SU, ST_WR_HD: begin
        bus.sram_ce_n  = 1'b0;
        bus.sram_dq_oe = 1'b1;
      end
      ST_WR_PL: begin
        bus.sram_ce_n  = 1'b0;
        bus.sram_dq_oe = 1'b1;
        bus.sram_we_n  = 1'b0;
      end
      ST_DONE: begin
        bus.if_ready = (port_reg == PORT_IF);
        bus.d_ready  = (port_reg == PORT_D);
      end
      default: ;
    endcase
  end

  assign bus.sram_ub_n   = bus.sram_ce_n;
  assign bus.sram_lb_n   = bus.sram_ce_n;
  assign bus.sram_addr   = addr_reg;
  assign bus.sram_dq_out = wdata_reg;
  assign bus.if_rdata    = if_rdata_reg;
  assign bus.d_rdata     = d_rdata_reg;

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// Bench for sram_mem_ctrl: two instances (default timing and RD_WAIT=3/WR_SETUP=0/WR_HOLD=0)
// against a 64K-word SRAM model, driven from a vector table plus corner-case sequences.
module tb_sram_mem_ctrl;

  typedef struct {
    int          inst;
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int          inst;
    bit          is_d;
    bit          chk_data;
    logic [15:0] data;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  if_req, d_req, d_we;
  logic [1:0]  if_ready, d_ready, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0] if_addr [2];
  logic [15:0] d_addr  [2];
  logic [15:0] d_wdata [2];
  logic [15:0] if_rdata[2];
  logic [15:0] d_rdata [2];
  logic [15:0] dq_out  [2];
  logic [15:0] dq_in   [2];
  logic [17:0] sram_addr[2];

  logic [15:0] mem [0:1][0:65535];
  logic        pl_en;
  int          pl_i;
  logic [15:0] pl_a, pl_d;

  int vectors = 0;
  int miscompares = 0;
  sb_t sb[$];
  vec_t vecs[11];
  int last_we_low;
  logic ce_trace[64];
  logic        wr_prev  [2];
  logic [17:0] addr_prev[2];
  logic [15:0] dq_prev  [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    sram_mem_ctrl_if #(.ADDR_W(18)) bus ();
    assign bus.if_req     = if_req[gi];
    assign bus.if_addr    = if_addr[gi];
    assign bus.d_req      = d_req[gi];
    assign bus.d_we       = d_we[gi];
    assign bus.d_addr     = d_addr[gi];
    assign bus.d_wdata    = d_wdata[gi];
    assign bus.sram_dq_in = dq_in[gi];
    assign if_ready[gi]   = bus.if_ready;
    assign if_rdata[gi]   = bus.if_rdata;
    assign d_ready[gi]    = bus.d_ready;
    assign d_rdata[gi]    = bus.d_rdata;
    assign sram_addr[gi]  = bus.sram_addr;
    assign dq_out[gi]     = bus.sram_dq_out;
    assign dq_oe[gi]      = bus.sram_dq_oe;
    assign ce_n[gi]       = bus.sram_ce_n;
    assign oe_n[gi]       = bus.sram_oe_n;
    assign we_n[gi]       = bus.sram_we_n;
    assign ub_n[gi]       = bus.sram_ub_n;
    assign lb_n[gi]       = bus.sram_lb_n;

    sram_mem_ctrl #(
      .ADDR_W  (18),
      .RD_WAIT (gi == 0 ? 1 : 3),
      .WR_SETUP(gi == 0 ? 1 : 0),
      .WR_PULSE(1),
      .WR_HOLD (gi == 0 ? 1 : 0)
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
    );
  end

  // SRAM model: data appears one cycle after CE/OE low; a write lands on the edge ending a WE pulse.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      dq_in[i] <= (!ce_n[i] && !oe_n[i]) ? mem[i][sram_addr[i][15:0]] : 16'hDEAD;
      if (!ce_n[i] && !we_n[i]) mem[i][sram_addr[i][15:0]] <= dq_out[i];
    end
    if (pl_en) mem[pl_i][pl_a] <= pl_d;
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic vec_t mkvec(input int inst, input bit is_d, input bit we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] exp_rdata, input int lat);
    vec_t v;
    v.inst = inst; v.is_d = is_d; v.we = we; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_lat = lat;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("oe_with_dq_oe[%0d]", i), 64'(!oe_n[i] && dq_oe[i]), 64'd0);
      check($sformatf("we_outside_write[%0d]", i), 64'(!we_n[i] && (ce_n[i] || !dq_oe[i])), 64'd0);
      check($sformatf("byte_en[%0d]", i), {ub_n[i], lb_n[i]}, {ce_n[i], ce_n[i]});
      if (!ce_n[i] && dq_oe[i] && wr_prev[i])
        check($sformatf("write_stable[%0d]", i), {sram_addr[i], dq_out[i]}, {addr_prev[i], dq_prev[i]});
      wr_prev[i]   = !ce_n[i] && dq_oe[i];
      addr_prev[i] = sram_addr[i];
      dq_prev[i]   = dq_out[i];
    end
  endtask

  task automatic preload(input int i, input logic [15:0] a, input logic [15:0] d);
    pl_i = i; pl_a = a; pl_d = d; pl_en = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  // Steps until n ready pulses appear on instance inst; each pulse is matched against the scoreboard.
  task automatic run_until(input int inst, input int n, input bit hold, input logic [15:0] exp_addr);
    int seen = 0;
    int k = 0;
    sb_t e;
    last_we_low = 0;
    while (seen < n && k < 40) begin
      tick();
      k++;
      ce_trace[k] = ce_n[inst];
      if (!we_n[inst]) last_we_low++;
      if (k == 1) begin
        check("first_addr", sram_addr[inst], {2'b00, exp_addr});
        if (!hold) begin
          if (d_req[inst]) begin
            d_addr[inst]  = ~d_addr[inst];
            d_wdata[inst] = ~d_wdata[inst];
          end else begin
            if_addr[inst] = ~if_addr[inst];
          end
        end
      end
      if (if_ready[inst] || d_ready[inst]) begin
        check("both_ready", 64'(if_ready[inst] && d_ready[inst]), 64'd0);
        if (sb.size() == 0) begin
          check("unexpected_ready", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check("ready_port", 64'(d_ready[inst]), 64'(e.is_d));
          check("ready_cycle", k, e.cyc);
          if (e.chk_data) check("rdata", e.is_d ? d_rdata[inst] : if_rdata[inst], e.data);
        end
        seen++;
        if (d_ready[inst] && !(hold && seen < n)) d_req[inst] = 1'b0;
        if (if_ready[inst]) if_req[inst] = 1'b0;
      end
    end
    if (seen < n) begin
      check("ready_timeout", seen, n);
      if_req[inst] = 1'b0;
      d_req[inst] = 1'b0;
    end
    tick();
  endtask

  task automatic push_sb(input int inst, input bit is_d, input bit chk, input logic [15:0] data, input int cyc);
    sb_t e;
    e.inst = inst; e.is_d = is_d; e.chk_data = chk; e.data = data; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic do_txn(input vec_t v);
    if (v.is_d) begin
      d_we[v.inst] = v.we; d_addr[v.inst] = v.addr; d_wdata[v.inst] = v.wdata; d_req[v.inst] = 1'b1;
    end else begin
      if_addr[v.inst] = v.addr; if_req[v.inst] = 1'b1;
    end
    push_sb(v.inst, v.is_d, !v.we, v.exp_rdata, v.exp_lat);
    run_until(v.inst, 1, 1'b0, v.addr);
    if (v.we) check("we_pulse_len", last_we_low, 1);
    $display("txn inst=%0d %s addr=%04h wdata=%04h exp_rdata=%04h lat=%0d", v.inst,
             v.is_d ? (v.we ? "store" : "load ") : "fetch", v.addr, v.wdata, v.exp_rdata, v.exp_lat);
  endtask

  initial begin
    int cnt;
    vecs[0]  = mkvec(0, 0, 0, 16'h0010, 16'h0000, 16'hA5C3, 3);
    vecs[1]  = mkvec(0, 1, 1, 16'h0200, 16'h1234, 16'h0000, 4);
    vecs[2]  = mkvec(0, 1, 0, 16'h0200, 16'h0000, 16'h1234, 3);
    vecs[3]  = mkvec(0, 1, 1, 16'hFFFF, 16'hBEEF, 16'h0000, 4);
    vecs[4]  = mkvec(0, 1, 0, 16'hFFFF, 16'h0000, 16'hBEEF, 3);
    vecs[5]  = mkvec(0, 0, 0, 16'h0200, 16'h0000, 16'h1234, 3);
    vecs[6]  = mkvec(1, 0, 0, 16'h0010, 16'h0000, 16'h5A5A, 5);
    vecs[7]  = mkvec(1, 1, 1, 16'h0300, 16'hCAFE, 16'h0000, 2);
    vecs[8]  = mkvec(1, 1, 0, 16'h0300, 16'h0000, 16'hCAFE, 5);
    vecs[9]  = mkvec(1, 1, 1, 16'h0000, 16'h0F0F, 16'h0000, 2);
    vecs[10] = mkvec(1, 0, 0, 16'h0000, 16'h0000, 16'h0F0F, 5);

    reset = 1'b0; pl_en = 1'b0; pl_i = 0; pl_a = '0; pl_d = '0;
    if_req = '0; d_req = '0; d_we = '0;
    for (int i = 0; i < 2; i++) begin
      if_addr[i] = '0; d_addr[i] = '0; d_wdata[i] = '0; wr_prev[i] = 1'b0;
      addr_prev[i] = '0; dq_prev[i] = '0;
    end

    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_ready_dqoe[%0d]", i), {if_ready[i], d_ready[i], dq_oe[i]}, 3'b000);
      check($sformatf("rst_strobes[%0d]", i), {ce_n[i], oe_n[i], we_n[i], ub_n[i], lb_n[i]}, 5'b11111);
      check($sformatf("rst_addr_dq[%0d]", i), {sram_addr[i], dq_out[i]}, 34'd0);
      check($sformatf("rst_rdata[%0d]", i), {if_rdata[i], d_rdata[i]}, 32'd0);
    end
    reset = 1'b1;
    tick();

    preload(0, 16'h0010, 16'hA5C3);
    preload(0, 16'h0040, 16'h1111);
    preload(1, 16'h0010, 16'h5A5A);

    for (int v = 0; v < 11; v++) do_txn(vecs[v]);
    check("if_rdata_hold", if_rdata[0], 16'h1234);
    check("d_rdata_hold", d_rdata[0], 16'hBEEF);

    // Collision: store and fetch raised together; data first, then the pending fetch.
    d_we[0] = 1'b1; d_addr[0] = 16'h0080; d_wdata[0] = 16'h5555; d_req[0] = 1'b1;
    if_addr[0] = 16'h0040; if_req[0] = 1'b1;
    push_sb(0, 1'b1, 1'b0, 16'h0000, 4);
    push_sb(0, 1'b0, 1'b1, 16'h1111, 8);
    run_until(0, 2, 1'b0, 16'h0080);
    check("collision_we_pulse", last_we_low, 1);
    $display("txn inst=0 collision store 0080 + fetch 0040");
    do_txn(mkvec(0, 1, 0, 16'h0080, 16'h0000, 16'h5555, 3));

    // Back-to-back loads from a held d_req at the top of the address space.
    d_we[0] = 1'b0; d_addr[0] = 16'hFFFF; d_req[0] = 1'b1;
    push_sb(0, 1'b1, 1'b1, 16'hBEEF, 3);
    push_sb(0, 1'b1, 1'b1, 16'hBEEF, 7);
    run_until(0, 2, 1'b1, 16'hFFFF);
    cnt = 0;
    for (int k = 1; k < 7; k++) if (ce_trace[k]) cnt++;
    check("b2b_idle_cycles", cnt, 2);
    $display("txn inst=0 back-to-back loads at FFFF");

    // Reset during the write pulse: strobes release at once and no ready is produced.
    d_we[0] = 1'b1; d_addr[0] = 16'h0500; d_wdata[0] = 16'h7777; d_req[0] = 1'b1;
    cnt = 0;
    while (we_n[0] && cnt < 10) begin
      tick();
      cnt++;
    end
    check("reach_wr_pulse", 64'(we_n[0]), 64'd0);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_strobes", {we_n[0], ce_n[0], dq_oe[0], d_ready[0]}, 4'b1100);
    d_req[0] = 1'b0;
    tick();
    check("rst_mid_no_ready", 64'(d_ready[0]), 64'd0);
    check("rst_mid_rdata", {if_rdata[0], d_rdata[0]}, 32'd0);
    reset = 1'b1;
    tick();
    check("post_rst_no_ready", {if_ready[0], d_ready[0]}, 2'b00);
    $display("txn inst=0 reset during write pulse");
    do_txn(mkvec(0, 0, 0, 16'h0010, 16'h0000, 16'hA5C3, 3));

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
